// File: rtl/eth_lb_pkg.sv
// Shared definitions for the Ethernet AXI-stream loopback: mode encodings,
// header-swap FSM states, MAC byte offsets and the MAC swap helper.
package eth_lb_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_SWAP = 2'd1,
      MODE_DROP = 2'd2
   } lb_mode_e;

   typedef enum logic [2:0] {
      ST_HDR0,
      ST_HDR1,
      ST_EMIT0,
      ST_EMIT1,
      ST_BODY
   } lb_state_e;

   localparam int unsigned MAC_SRC_OFS = 6;
   localparam int unsigned MAC_HDR_END = 12;

   // Encoding 3 is not a distinct mode and behaves as pass.
   function automatic lb_mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return MODE_SWAP;
         2'd2:    return MODE_DROP;
         default: return MODE_PASS;
      endcase
   endfunction

   function automatic logic [127:0] mac_swap(input logic [127:0] d);
      logic [127:0] r;
      r = d;
      r[8*MAC_SRC_OFS-1:0]           = d[8*MAC_HDR_END-1:8*MAC_SRC_OFS];
      r[8*MAC_HDR_END-1:8*MAC_SRC_OFS] = d[8*MAC_SRC_OFS-1:0];
      return r;
   endfunction

endpackage

// File: rtl/eth_lb_stats.sv
// Four saturating 32-bit statistics counters (frames, drops, runts, errors),
// each advanced by its own strobe; all strobes may fire in the same cycle.
module eth_lb_stats (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_inc_i,
   input  logic        drop_inc_i,
   input  logic        runt_inc_i,
   input  logic        error_inc_i,
   output logic [31:0] frame_count_o,
   output logic [31:0] drop_count_o,
   output logic [31:0] runt_count_o,
   output logic [31:0] error_count_o
);

   logic [3:0]  inc;
   logic [31:0] cnt_q [4];

   assign inc = {error_inc_i, runt_inc_i, drop_inc_i, frame_inc_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (inc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 32'd1;
         end
      end
   end

   assign frame_count_o = cnt_q[0];
   assign drop_count_o  = cnt_q[1];
   assign runt_count_o  = cnt_q[2];
   assign error_count_o = cnt_q[3];

endmodule

// File: rtl/eth_axis_loopback.sv
// Ethernet MAC RX->TX AXI-stream loopback: pass, MAC-address swap or drop per frame.
// Statistics counters are built only when ETH_LB_STATS_EN is defined.
module eth_axis_loopback
   import eth_lb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   input  logic [1:0]            mode,
   output logic [31:0]           frame_count,
   output logic [31:0]           drop_count,
   output logic [31:0]           runt_count,
   output logic [31:0]           error_count
);

   localparam bit NARROW = (DATA_WIDTH == 64);

   lb_state_e             state_q;
   lb_mode_e              mode_q, cur_mode;
   logic                  rdy_q;
   logic                  out_valid_q, out_last_q, out_user_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [KEEP_WIDTH-1:0] out_keep_q;
   logic [DATA_WIDTH-1:0] h0_data_q, h1_data_q;
   logic [KEEP_WIDTH-1:0] h0_keep_q, h1_keep_q;
   logic                  h0_user_q, h1_user_q, h1_last_q;

   logic                  out_free, accept, tready;
   logic                  load_en, load_last, load_user;
   logic [DATA_WIDTH-1:0] load_data, swap_lo, swap_hi;
   logic [KEEP_WIDTH-1:0] load_keep;

   // On a narrow bus the MAC pair straddles beats 0 and 1, so swap the joined pair.
   if (NARROW) begin : g_narrow
      logic [127:0] pair_sw;
      assign pair_sw = mac_swap({s_axis_tdata, h0_data_q});
      assign swap_lo = pair_sw[63:0];
      assign swap_hi = pair_sw[127:64];
   end else begin : g_wide
      assign swap_lo = mac_swap(s_axis_tdata);
      assign swap_hi = s_axis_tdata;
   end

   assign cur_mode = (state_q == ST_HDR0) ? decode_mode(mode) : mode_q;
   assign out_free = !out_valid_q || m_axis_tready;
   assign accept   = s_axis_tvalid && tready;

   always_comb begin
      tready = 1'b0;
      if (rdy_q) begin
         case (state_q)
            ST_EMIT0: tready = 1'b0;
            ST_EMIT1: tready = !h1_last_q && out_free;
            default:  tready = (cur_mode == MODE_DROP) ? 1'b1 : out_free;
         endcase
      end
   end

   always_comb begin
      load_en   = 1'b0;
      load_data = s_axis_tdata;
      load_keep = s_axis_tkeep;
      load_last = s_axis_tlast;
      load_user = s_axis_tuser;
      case (state_q)
         ST_HDR0: begin
            load_en = accept && (cur_mode != MODE_DROP) &&
                      !((cur_mode == MODE_SWAP) && NARROW && !s_axis_tlast);
            if ((cur_mode == MODE_SWAP) && !NARROW) load_data = swap_lo;
         end
         ST_HDR1: begin
            load_en   = accept;
            load_data = swap_lo;
            load_keep = h0_keep_q;
            load_last = 1'b0;
            load_user = h0_user_q;
         end
         ST_EMIT0: begin
            load_en   = out_free;
            load_data = h1_data_q;
            load_keep = h1_keep_q;
            load_last = h1_last_q;
            load_user = h1_user_q;
         end
         default: load_en = accept && (mode_q != MODE_DROP);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HDR0;
         mode_q      <= MODE_PASS;
         rdy_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_user_q  <= 1'b0;
         h0_data_q   <= '0;
         h0_keep_q   <= '0;
         h0_user_q   <= 1'b0;
         h1_data_q   <= '0;
         h1_keep_q   <= '0;
         h1_last_q   <= 1'b0;
         h1_user_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (load_en) begin
            out_valid_q <= 1'b1;
            out_data_q  <= load_data;
            out_keep_q  <= load_keep;
            out_last_q  <= load_last;
            out_user_q  <= load_user;
         end else if (m_axis_tready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            ST_HDR0: if (accept) begin
               mode_q <= cur_mode;
               if ((cur_mode == MODE_SWAP) && NARROW && !s_axis_tlast) begin
                  h0_data_q <= s_axis_tdata;
                  h0_keep_q <= s_axis_tkeep;
                  h0_user_q <= s_axis_tuser;
                  state_q   <= ST_HDR1;
               end else if (!s_axis_tlast) begin
                  state_q <= ST_BODY;
               end
            end
            ST_HDR1: if (accept) begin
               h1_data_q <= swap_hi;
               h1_keep_q <= s_axis_tkeep;
               h1_last_q <= s_axis_tlast;
               h1_user_q <= s_axis_tuser;
               state_q   <= ST_EMIT0;
            end
            ST_EMIT0: if (out_free) state_q <= ST_EMIT1;
            ST_EMIT1: begin
               if (h1_last_q)   state_q <= ST_HDR0;
               else if (accept) state_q <= s_axis_tlast ? ST_HDR0 : ST_BODY;
            end
            ST_BODY: if (accept && s_axis_tlast) state_q <= ST_HDR0;
            default: state_q <= ST_HDR0;
         endcase
      end
   end

   assign s_axis_tready = tready;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tkeep  = out_keep_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tuser  = out_user_q;

`ifdef ETH_LB_STATS_EN
   logic frame_inc, drop_inc, runt_inc, error_inc;

   assign frame_inc = accept && s_axis_tlast;
   assign error_inc = frame_inc && s_axis_tuser;
   assign drop_inc  = frame_inc && (cur_mode == MODE_DROP);
   assign runt_inc  = frame_inc && (state_q == ST_HDR0) && (cur_mode == MODE_SWAP) && NARROW;

   eth_lb_stats u_stats (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_inc_i   (frame_inc),
      .drop_inc_i    (drop_inc),
      .runt_inc_i    (runt_inc),
      .error_inc_i   (error_inc),
      .frame_count_o (frame_count),
      .drop_count_o  (drop_count),
      .runt_count_o  (runt_count),
      .error_count_o (error_count)
   );
`else
   assign frame_count = '0;
   assign drop_count  = '0;
   assign runt_count  = '0;
   assign error_count = '0;
`endif

endmodule

// File: tb/tb_eth_axis_loopback.sv
// Scoreboard bench for eth_axis_loopback (64-bit bus); counter expectations follow
// whether ETH_LB_STATS_EN is defined.
module tb_eth_axis_loopback;

   localparam int DW = 64;
   localparam int KW = 8;
`ifdef ETH_LB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk, rst_n;
   logic [DW-1:0] s_tdata, m_tdata;
   logic [KW-1:0] s_tkeep, m_tkeep;
   logic          s_tvalid, s_tlast, s_tuser, s_tready;
   logic          m_tvalid, m_tlast, m_tuser, m_tready;
   logic [1:0]    mode;
   logic [31:0]   frame_count, drop_count, runt_count, error_count;

   eth_axis_loopback #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
      .mode(mode),
      .frame_count(frame_count), .drop_count(drop_count),
      .runt_count(runt_count), .error_count(error_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   beat_t       exp_q[$];
   int unsigned total = 0, bad = 0;
   int unsigned m_frames = 0, m_drops = 0, m_runts = 0, m_errs = 0;
   int unsigned n_out = 0;
   int unsigned idle_pct = 0, rdy_pct = 100;
   bit          m_first = 1'b1, prev_stall = 1'b0;
   logic [1:0]  m_mode;
   int unsigned m_nb;
   beat_t       m_b0, prev_beat;
   logic [63:0] first_out;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] norm(input logic [1:0] m);
      return (m == 2'd3) ? 2'd0 : m;
   endfunction

   function automatic void swap_pair(input beat_t b0, input beat_t b1, output beat_t o0, output beat_t o1);
      logic [7:0] by [16];
      logic [7:0] t;
      for (int i = 0; i < 8; i++) begin
         by[i]     = b0.data[8*i +: 8];
         by[8 + i] = b1.data[8*i +: 8];
      end
      for (int i = 0; i < 6; i++) begin
         t = by[i]; by[i] = by[6 + i]; by[6 + i] = t;
      end
      o0 = b0; o1 = b1;
      for (int i = 0; i < 8; i++) begin
         o0.data[8*i +: 8] = by[i];
         o1.data[8*i +: 8] = by[8 + i];
      end
   endfunction

   // Output scoreboard and input-side reference model, both sampled mid-cycle.
   always @(negedge clk) begin : mon
      beat_t cur, e, b, o0, o1;
      if (rst_n) begin
         cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
         if (m_tvalid && prev_stall) check("hold_stable", cur, prev_beat);
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) check("extra_out", cur, 0);
            else begin
               e = exp_q.pop_front();
               check("out_beat", cur, e);
            end
            if (n_out == 0) first_out = m_tdata;
            n_out++;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_beat  = cur;

         if (s_tvalid && s_tready) begin
            b = {s_tdata, s_tkeep, s_tlast, s_tuser};
            if (m_first) begin
               m_mode  = norm(mode);
               m_nb    = 0;
               m_first = 1'b0;
            end
            case (m_mode)
               2'd0: exp_q.push_back(b);
               2'd1: begin
                  if (m_nb == 0) begin
                     if (b.last) begin exp_q.push_back(b); m_runts++; end
                     else m_b0 = b;
                  end else if (m_nb == 1) begin
                     swap_pair(m_b0, b, o0, o1);
                     exp_q.push_back(o0);
                     exp_q.push_back(o1);
                  end else exp_q.push_back(b);
               end
               default: ;
            endcase
            m_nb++;
            if (b.last) begin
               m_frames++;
               if (b.user) m_errs++;
               if (m_mode == 2'd2) m_drops++;
               m_first = 1'b1;
            end
         end
      end
   end

   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         m_tready = ($urandom_range(99) < rdy_pct);
      end
   end

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic u, output int cyc);
      bit acc;
      cyc = 0;
      while (idle_pct != 0 && $urandom_range(99) < idle_pct) begin
         s_tvalid = 1'b0;
         @(posedge clk); #1;
      end
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
      acc = 1'b0;
      while (!acc && cyc < 500) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk); #1;
         cyc++;
      end
      s_tvalid = 1'b0;
      if (!acc) check("in_timeout", 0, 1);
   endtask

   task automatic send_frame(input logic [1:0] md, input int nb, input logic [47:0] dst,
                             input logic [47:0] src, input logic user_last, input bit toggle,
                             input logic [7:0] last_keep, input bit lat_chk, output int cycles);
      logic [7:0]  by [128];
      logic [63:0] d;
      int          c;
      for (int i = 0; i < nb * 8; i++) begin
         if (i < 6)       by[i] = dst[8*(5 - i) +: 8];
         else if (i < 12) by[i] = src[8*(11 - i) +: 8];
         else             by[i] = 8'($urandom);
      end
      mode   = md;
      cycles = 0;
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < 8; j++) d[8*j +: 8] = by[8*b + j];
         send_beat(d, (b == nb - 1) ? last_keep : 8'hFF, b == nb - 1,
                   (b == nb - 1) ? user_last : 1'b0, c);
         cycles += c;
         if (lat_chk && b == 0) begin
            check("lat_valid", m_tvalid, 1);
            check("lat_data", m_tdata, d);
         end
         if (toggle) mode = 2'($urandom_range(3));
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frames"}, frame_count, STATS ? m_frames : 0);
      check({tag, "_drops"},  drop_count,  STATS ? m_drops  : 0);
      check({tag, "_runts"},  runt_count,  STATS ? m_runts  : 0);
      check({tag, "_errors"}, error_count, STATS ? m_errs   : 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: got=running exp=finished");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int cyc, sum;
      rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
      s_tlast = 1'b0; s_tuser = 1'b0; mode = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", {m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
      check("rst_tready", s_tready, 0);
      check_counts("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rel_tready_low", s_tready, 0);
      @(posedge clk); #1;
      check("rel_tready_high", s_tready, 1);

      // Pass, 8 beats, full throughput
      n_out = 0;
      send_frame(2'd0, 8, 48'h0A0B0C0D0E0F, 48'h111213141516, 1'b0, 1'b0, 8'hFF, 1'b1, sum);
      drain();
      check("pass_nout", n_out, 8);
      check("pass_frames", frame_count, STATS ? 1 : 0);

      // Swap, 8 beats
      n_out = 0;
      send_frame(2'd1, 8, 48'h020000000001, 48'h020000000002, 1'b0, 1'b0, 8'hFF, 1'b0, sum);
      drain();
      check("swap_nout", n_out, 8);
      check("swap_first", first_out, 64'h0002020000000002);

      // Runt swap frame
      n_out = 0;
      send_frame(2'd1, 1, 48'h020000000001, 48'h020000000002, 1'b0, 1'b0, 8'h0F, 1'b0, sum);
      drain();
      check("runt_nout", n_out, 1);
      check("runt_count", runt_count, STATS ? 1 : 0);

      // Drop, three 4-beat frames: one cycle per beat, nothing out
      n_out = 0;
      cyc = 0;
      for (int f = 0; f < 3; f++) begin
         send_frame(2'd2, 4, 48'h1, 48'h2, 1'b0, 1'b0, 8'hFF, 1'b0, sum);
         cyc += sum;
      end
      drain();
      check("drop_cycles", cyc, 12);
      check("drop_nout", n_out, 0);
      check("drop_count", drop_count, STATS ? 3 : 0);
      check("drop_frames", frame_count, STATS ? 6 : 0);
      check_counts("det");

      // Random handshakes, mixed modes, mid-frame mode toggling
      idle_pct = 50;
      rdy_pct  = 50;
      for (int f = 0; f < 100; f++) begin
         send_frame(2'($urandom_range(3)), $urandom_range(1, 10), 48'($urandom), 48'($urandom),
                    (f % 20) == 7, 1'b1, 8'($urandom_range(1, 255)), 1'b0, sum);
      end
      drain();
      check("rand_errors", error_count, STATS ? 5 : 0);
      check_counts("rand");

      // Reset during beat 3 of a swap frame
      idle_pct = 0;
      rdy_pct  = 100;
      mode     = 2'd1;
      for (int b = 0; b < 3; b++) send_beat(64'h1111_0000 + 64'(b), 8'hFF, 1'b0, 1'b0, cyc);
      s_tdata = 64'h3333; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("mrst_tvalid", m_tvalid, 0);
      check("mrst_tdata", {m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
      check("mrst_tready", s_tready, 0);
      check("mrst_frames", frame_count, 0);
      check("mrst_drops", drop_count, 0);
      check("mrst_runts", runt_count, 0);
      check("mrst_errors", error_count, 0);
      s_tvalid = 1'b0;
      exp_q.delete();
      m_first = 1'b1; prev_stall = 1'b0;
      m_frames = 0; m_drops = 0; m_runts = 0; m_errs = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_out = 0;
      send_frame(2'd1, 8, 48'h020000000001, 48'h020000000002, 1'b0, 1'b0, 8'hFF, 1'b0, sum);
      drain();
      check("post_nout", n_out, 8);
      check("post_first", first_out, 64'h0002020000000002);
      check_counts("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
